// File: rtl/led_matrix_pkg.sv
// Shared types and defaults for the LED matrix row scanner and its column shifter.
package led_matrix_pkg;

    localparam int ROWS_DEFAULT         = 8;
    localparam int COLS_DEFAULT         = 8;
    localparam int SCLK_DIV_DEFAULT     = 2;
    localparam int BLANK_CYCLES_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BLANK   = 3'd1,
        ST_FETCH   = 3'd2,
        ST_LOAD    = 3'd3,
        ST_SHIFT   = 3'd4,
        ST_LATCH   = 3'd5,
        ST_DISPLAY = 3'd6
    } scanState_e;

    // Counter width that can index 0..n-1, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_col_shifter.sv
// Serialises one matrix row MSB-first onto col_sdo with a divided col_sclk.
module led_col_shifter
    import led_matrix_pkg::*;
#(
    parameter int COLS     = COLS_DEFAULT,
    parameter int SCLK_DIV = SCLK_DIV_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [COLS-1:0] data_i,
    output logic            sdo_o,
    output logic            sclk_o,
    output logic            done_o
);

    localparam int DW = idxWidth(SCLK_DIV);
    localparam int CW = idxWidth(COLS);

    logic [COLS-1:0] shReg_q, shReg_d;
    logic [DW-1:0]   divCnt_q, divCnt_d;
    logic [CW-1:0]   bitCnt_q, bitCnt_d;
    logic            sdo_q, sdo_d;
    logic            sclk_q, sclk_d;
    logic            active_q, active_d;
    logic            halfEnd;
    logic            lastBit;

    assign halfEnd = active_q && (divCnt_q == DW'(SCLK_DIV - 1));
    assign lastBit = (bitCnt_q == CW'(COLS - 1));
    // Asserted in the final cycle of the last high phase so the FSM leaves SHIFT with sclk low.
    assign done_o  = halfEnd && sclk_q && lastBit;
    assign sdo_o   = sdo_q;
    assign sclk_o  = sclk_q;

    always_comb begin
        shReg_d  = shReg_q;
        divCnt_d = divCnt_q;
        bitCnt_d = bitCnt_q;
        sdo_d    = sdo_q;
        sclk_d   = sclk_q;
        active_d = active_q;
        if (load_i) begin
            shReg_d  = data_i << 1;
            sdo_d    = data_i[COLS-1];
            sclk_d   = 1'b0;
            divCnt_d = '0;
            bitCnt_d = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (halfEnd) begin
                divCnt_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    if (lastBit) begin
                        active_d = 1'b0;
                    end else begin
                        bitCnt_d = bitCnt_q + CW'(1);
                        sdo_d    = shReg_q[COLS-1];
                        shReg_d  = shReg_q << 1;
                    end
                end
            end else begin
                divCnt_d = divCnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shReg_q  <= '0;
            divCnt_q <= '0;
            bitCnt_q <= '0;
            sdo_q    <= 1'b0;
            sclk_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            shReg_q  <= shReg_d;
            divCnt_q <= divCnt_d;
            bitCnt_q <= bitCnt_d;
            sdo_q    <= sdo_d;
            sclk_q   <= sclk_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/led_matrix_row_scanner.sv
// Refreshes one LED matrix row per timer tick: blank, fetch, shift, latch, display.
module led_matrix_row_scanner
    import led_matrix_pkg::*;
#(
    parameter int  ROWS         = ROWS_DEFAULT,
    parameter int  COLS         = COLS_DEFAULT,
    parameter int  SCLK_DIV     = SCLK_DIV_DEFAULT,
    parameter int  BLANK_CYCLES = BLANK_CYCLES_DEFAULT,
    localparam int ROW_W        = idxWidth(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    output logic [ROW_W-1:0] rd_addr,
    input  logic [COLS-1:0]  rd_data,
    output logic             col_sdo,
    output logic             col_sclk,
    output logic             col_latch,
    output logic [ROWS-1:0]  row_sel,
    output logic             oe_n,
    output logic             busy,
    output logic             frame_start,
    output logic             overrun
);

    localparam int BW = idxWidth(BLANK_CYCLES);

    scanState_e       state_q;
    logic [BW-1:0]    blankCnt_q;
    logic [ROW_W-1:0] nextRow_q;
    logic [ROW_W-1:0] rdAddr_q;
    logic [ROWS-1:0]  rowSel_q;
    logic             colLatch_q;
    logic             oeN_q;
    logic             busy_q;
    logic             frameStart_q;
    logic             overrun_q;
    logic             shiftDone;
    logic             idleLike;

    assign idleLike    = (state_q == ST_IDLE) || (state_q == ST_DISPLAY);
    assign rd_addr     = rdAddr_q;
    assign row_sel     = rowSel_q;
    assign col_latch   = colLatch_q;
    assign oe_n        = oeN_q;
    assign busy        = busy_q;
    assign frame_start = frameStart_q;
    assign overrun     = overrun_q;

    led_col_shifter #(
        .COLS     (COLS),
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == ST_LOAD),
        .data_i (rd_data),
        .sdo_o  (col_sdo),
        .sclk_o (col_sclk),
        .done_o (shiftDone)
    );

    // Ticks are only accepted when idle or displaying; anything else flags overrun and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            blankCnt_q   <= '0;
            nextRow_q    <= '0;
            rdAddr_q     <= '0;
            rowSel_q     <= '0;
            colLatch_q   <= 1'b0;
            oeN_q        <= 1'b1;
            busy_q       <= 1'b0;
            frameStart_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (tick_in && !idleLike) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_DISPLAY: begin
                    if (tick_in) begin
                        state_q    <= ST_BLANK;
                        blankCnt_q <= '0;
                        oeN_q      <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (blankCnt_q == BW'(BLANK_CYCLES - 1)) begin
                        state_q  <= ST_FETCH;
                        rdAddr_q <= nextRow_q;
                    end else begin
                        blankCnt_q <= blankCnt_q + BW'(1);
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (shiftDone) begin
                        state_q      <= ST_LATCH;
                        colLatch_q   <= 1'b1;
                        rowSel_q     <= ROWS'(1) << nextRow_q;
                        frameStart_q <= (nextRow_q == '0);
                        nextRow_q    <= (nextRow_q == ROW_W'(ROWS - 1)) ? '0 : nextRow_q + ROW_W'(1);
                    end
                end
                ST_LATCH: begin
                    state_q      <= ST_DISPLAY;
                    colLatch_q   <= 1'b0;
                    frameStart_q <= 1'b0;
                    oeN_q        <= 1'b0;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_row_scanner.sv
// Directed self-checking bench for led_matrix_row_scanner at default parameters.
module tb_led_matrix_row_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic [2:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       col_sdo;
    logic       col_sclk;
    logic       col_latch;
    logic [7:0] row_sel;
    logic       oe_n;
    logic       busy;
    logic       frame_start;
    logic       overrun;

    logic [7:0] frameBuf [0:7] = '{8'hA5, 8'h3C, 8'h81, 8'h7E, 8'h0F, 8'hF0, 8'h55, 8'hC3};

    int compareCount = 0;
    int failCount    = 0;
    int sclkRises    = 0;
    int latchCount   = 0;
    logic       prevSclk = 1'b0;
    logic [7:0] sdoBits  = 8'h00;

    led_matrix_row_scanner dut (
        .clk         (clk),
        .rst         (rst),
        .tick_in     (tick_in),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .col_sdo     (col_sdo),
        .col_sclk    (col_sclk),
        .col_latch   (col_latch),
        .row_sel     (row_sel),
        .oe_n        (oe_n),
        .busy        (busy),
        .frame_start (frame_start),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Frame buffer with one cycle of read latency.
    always @(posedge clk) rd_data <= frameBuf[rd_addr];

    // Records what the column drivers see on each rising shift clock.
    always @(negedge clk) begin
        if (col_sclk && !prevSclk) begin
            sclkRises = sclkRises + 1;
            sdoBits   = {sdoBits[6:0], col_sdo};
        end
        prevSclk = col_sclk;
        if (col_latch) latchCount = latchCount + 1;
    end

    task automatic applyStimulus(input logic tickVal, input logic rstVal);
        tick_in = tickVal;
        rst     = rstVal;
        @(posedge clk);
        #1;
        tick_in = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_sdo"}, 32'(col_sdo), 0);
        checkOutput({tag, "_sclk"}, 32'(col_sclk), 0);
        checkOutput({tag, "_latch"}, 32'(col_latch), 0);
        checkOutput({tag, "_rowsel"}, 32'(row_sel), 0);
        checkOutput({tag, "_oen"}, 32'(oe_n), 1);
        checkOutput({tag, "_rdaddr"}, 32'(rd_addr), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_fstart"}, 32'(frame_start), 0);
        checkOutput({tag, "_overrun"}, 32'(overrun), 0);
    endtask

    initial begin
        int riseBase;
        int latchBase;

        // Reset then a long idle stretch.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkResetValues("reset");
        riseBase = sclkRises;
        stepCycles(100);
        checkOutput("idle_rowsel", 32'(row_sel), 0);
        checkOutput("idle_oen", 32'(oe_n), 1);
        checkOutput("idle_sclk_edges", 32'(sclkRises - riseBase), 0);

        // Single refresh of row 0 (8'hA5); cycle numbers are relative to the tick.
        riseBase = sclkRises;
        applyStimulus(1'b1, 1'b0);
        checkOutput("c1_oen", 32'(oe_n), 1);
        checkOutput("c1_busy", 32'(busy), 1);
        stepCycles(4);
        checkOutput("c5_rdaddr", 32'(rd_addr), 0);
        stepCycles(2);
        checkOutput("c7_sdo", 32'(col_sdo), 1);
        checkOutput("c7_sclk", 32'(col_sclk), 0);
        stepCycles(2);
        checkOutput("c9_sclk", 32'(col_sclk), 1);
        stepCycles(2);
        checkOutput("c11_sdo", 32'(col_sdo), 0);
        stepCycles(28);
        checkOutput("c39_latch", 32'(col_latch), 1);
        checkOutput("c39_rowsel", 32'(row_sel), 32'h01);
        checkOutput("c39_fstart", 32'(frame_start), 1);
        checkOutput("c39_oen", 32'(oe_n), 1);
        checkOutput("c39_busy", 32'(busy), 1);
        stepCycles(1);
        checkOutput("c40_oen", 32'(oe_n), 0);
        checkOutput("c40_busy", 32'(busy), 0);
        checkOutput("c40_latch", 32'(col_latch), 0);
        checkOutput("c40_sclk", 32'(col_sclk), 0);
        checkOutput("row0_sclk_edges", 32'(sclkRises - riseBase), 8);
        checkOutput("row0_bits", 32'(sdoBits), 32'hA5);
        stepCycles(60);

        // Rows 1..7 walk the one-hot row select, then row 0 comes round again.
        for (int r = 1; r < 8; r++) begin
            applyStimulus(1'b1, 1'b0);
            stepCycles(38);
            checkOutput($sformatf("walk%0d_rowsel", r), 32'(row_sel), 32'(8'h01 << r));
            checkOutput($sformatf("walk%0d_fstart", r), 32'(frame_start), 0);
            stepCycles(1);
            checkOutput($sformatf("walk%0d_bits", r), 32'(sdoBits), 32'(frameBuf[r]));
            stepCycles(60);
        end
        applyStimulus(1'b1, 1'b0);
        stepCycles(38);
        checkOutput("wrap_rowsel", 32'(row_sel), 32'h01);
        checkOutput("wrap_fstart", 32'(frame_start), 1);
        stepCycles(61);

        // Overrun: second tick 20 cycles into a refresh is dropped.
        applyStimulus(1'b0, 1'b1);
        checkOutput("ovr_pre", 32'(overrun), 0);
        latchBase = latchCount;
        applyStimulus(1'b1, 1'b0);
        stepCycles(19);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ovr_set", 32'(overrun), 1);
        checkOutput("ovr_busy", 32'(busy), 1);
        stepCycles(1000);
        checkOutput("ovr_latches", 32'(latchCount - latchBase), 1);
        checkOutput("ovr_sticky", 32'(overrun), 1);
        checkOutput("ovr_rowsel", 32'(row_sel), 32'h01);

        // Reset in the middle of shifting row 1 (8'h3C puts a 1 on sdo at cycle 15).
        applyStimulus(1'b1, 1'b0);
        stepCycles(14);
        checkOutput("mid_sdo", 32'(col_sdo), 1);
        checkOutput("mid_rdaddr", 32'(rd_addr), 1);
        applyStimulus(1'b0, 1'b1);
        checkResetValues("midrst");
        stepCycles(2);
        applyStimulus(1'b1, 1'b0);
        stepCycles(4);
        checkOutput("post_rdaddr", 32'(rd_addr), 0);
        stepCycles(34);
        checkOutput("post_rowsel", 32'(row_sel), 32'h01);
        checkOutput("post_fstart", 32'(frame_start), 1);
        stepCycles(1);
        checkOutput("post_bits", 32'(sdoBits), 32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
